wrapper_engine_output_buffer: RTL and testbench

- Parametrised capture/packetiser between a hashing engine's unhandshaked output and the wrapper's AHB packet deconstructor.
- Qualifies engine results with an optional final-digest filter and buffers them in a DEPTH-entry FIFO.
- Splits each ENGWIDTH-bit result into ENGWIDTH/PKTWIDTH valid/ready sub-packets with last/remain sideband.
- Raises the DMA data request at a programmable fill threshold; counts and flags results dropped on overflow.

---
 rtl/wrapper_engine_output_buffer.sv | 110 +++++++++++
 tb/tb_wrapper_engine_output_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wrapper_engine_output_buffer.sv
// Captures unhandshaked engine results into a FIFO of whole results and replays
// each one as NUMPKT valid/ready sub-packets, lowest slice first.
module wrapper_engine_output_buffer #(
  parameter int ENGWIDTH  = 256,
  parameter int PKTWIDTH  = 128,
  parameter int DEPTH     = 4,
  parameter int REQTHRESH = 1,
  localparam int NUMPKT    = ENGWIDTH / PKTWIDTH,
  localparam int REMWIDTH  = (NUMPKT > 1) ? $clog2(NUMPKT) : 1,
  localparam int FILLWIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENGWIDTH-1:0]  eng_data,
  input  logic                 eng_valid,
  input  logic                 eng_last,
  input  logic                 filter_en,
  output logic [PKTWIDTH-1:0]  packet_data,
  output logic                 packet_data_last,
  output logic [REMWIDTH-1:0]  packet_data_remain,
  output logic                 packet_data_valid,
  input  logic                 packet_data_ready,
  output logic                 data_req,
  output logic [FILLWIDTH-1:0] fill_level,
  output logic                 overflow,
  input  logic                 overflow_clr,
  output logic [7:0]           drop_count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [REMWIDTH-1:0] LAST_IDX = REMWIDTH'(NUMPKT - 1);

  logic [ENGWIDTH-1:0]  mem [DEPTH];
  logic [PTRW-1:0]      wr_ptr;
  logic [PTRW-1:0]      rd_ptr;
  logic [REMWIDTH-1:0]  sub_idx;
  logic [ENGWIDTH-1:0]  head;
  logic [PKTWIDTH-1:0]  head_slices [NUMPKT];

  logic wr_q;
  logic full;
  logic hs;
  logic pop;
  logic wr_accept;
  logic drop;

  // Handshake: a sub-packet transfers on any edge where packet_data_valid and
  // packet_data_ready are both high; while valid && !ready the outputs hold.
  assign wr_q      = eng_valid && (!filter_en || eng_last);
  assign full      = (fill_level == FILLWIDTH'(DEPTH));
  assign hs        = packet_data_valid && packet_data_ready;
  assign pop       = hs && packet_data_last;
  assign wr_accept = wr_q && (!full || pop);
  assign drop      = wr_q && full && !pop;

  assign head = mem[rd_ptr];
  for (genvar i = 0; i < NUMPKT; i++) begin : g_slice
    assign head_slices[i] = head[i*PKTWIDTH +: PKTWIDTH];
  end

  assign packet_data        = head_slices[sub_idx];
  assign packet_data_last   = (sub_idx == LAST_IDX);
  assign packet_data_remain = LAST_IDX - sub_idx;
  assign packet_data_valid  = (fill_level != '0);
  assign data_req           = (fill_level >= FILLWIDTH'(REQTHRESH));

  // Storage is deliberately left unreset; fill_level alone decides what is live.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= eng_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sub_idx    <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTRW'(1);

      if (hs) begin
        if (packet_data_last) begin
          sub_idx <= '0;
          rd_ptr  <= rd_ptr + PTRW'(1);
        end else begin
          sub_idx <= sub_idx + REMWIDTH'(1);
        end
      end

      case ({wr_accept, pop})
        2'b10:   fill_level <= fill_level + FILLWIDTH'(1);
        2'b01:   fill_level <= fill_level - FILLWIDTH'(1);
        default: fill_level <= fill_level;
      endcase

      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
        overflow <= 1'b1;
        if (overflow_clr)              drop_count <= 8'd1;
        else if (drop_count != 8'hFF)  drop_count <= drop_count + 8'd1;
      end else if (overflow_clr) begin
        overflow   <= 1'b0;
        drop_count <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_wrapper_engine_output_buffer.sv
// Bench for wrapper_engine_output_buffer: queue-based model checked every cycle
// plus directed scenarios with literal expectations.
module tb_wrapper_engine_output_buffer;

  localparam int ENGW = 256;
  localparam int PKTW = 128;
  localparam int DEP  = 4;
  localparam int NP   = ENGW / PKTW;

  logic            clk = 1'b0;
  logic            rst;
  logic [ENGW-1:0] eng_data;
  logic            eng_valid;
  logic            eng_last;
  logic            filter_en;
  logic [PKTW-1:0] packet_data;
  logic            packet_data_last;
  logic [0:0]      packet_data_remain;
  logic            packet_data_valid;
  logic            packet_data_ready;
  logic            data_req;
  logic [2:0]      fill_level;
  logic            overflow;
  logic            overflow_clr;
  logic [7:0]      drop_count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  wrapper_engine_output_buffer #(
    .ENGWIDTH(ENGW), .PKTWIDTH(PKTW), .DEPTH(DEP), .REQTHRESH(3)
  ) dut (
    .clk(clk), .rst(rst), .eng_data(eng_data), .eng_valid(eng_valid),
    .eng_last(eng_last), .filter_en(filter_en), .packet_data(packet_data),
    .packet_data_last(packet_data_last), .packet_data_remain(packet_data_remain),
    .packet_data_valid(packet_data_valid), .packet_data_ready(packet_data_ready),
    .data_req(data_req), .fill_level(fill_level), .overflow(overflow),
    .overflow_clr(overflow_clr), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [ENGW-1:0] exp_q[$];
  int              m_sub  = 0;
  bit              m_ovf  = 0;
  int              m_drop = 0;

  always @(posedge clk) begin
    bit wrq, full, pop, hs;
    if (rst) begin
      exp_q.delete();
      m_sub  = 0;
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      wrq  = eng_valid && (!filter_en || eng_last);
      full = (exp_q.size() == DEP);
      hs   = (exp_q.size() != 0) && packet_data_ready;
      pop  = hs && (m_sub == NP - 1);
      if (hs) begin
        if (pop) begin
          m_sub = 0;
          void'(exp_q.pop_front());
        end else begin
          m_sub++;
        end
      end
      if (wrq && (!full || pop)) exp_q.push_back(eng_data);
      if (wrq && full && !pop) begin
        m_ovf  = 1;
        m_drop = overflow_clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (overflow_clr) begin
        m_ovf  = 0;
        m_drop = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [ENGW-1:0] act, input logic [ENGW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are registered, so the negedge is a quiet point.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", packet_data_valid, exp_q.size() != 0);
      chk("m_fill", fill_level, exp_q.size());
      chk("m_req", data_req, exp_q.size() >= 3);
      chk("m_ovf", overflow, m_ovf);
      chk("m_drop", drop_count, m_drop);
      chk("m_last", packet_data_last, m_sub == NP - 1);
      chk("m_remain", packet_data_remain, NP - 1 - m_sub);
      if (exp_q.size() != 0) chk("m_data", packet_data, exp_q[0][m_sub*PKTW +: PKTW]);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    eng_valid    = 1'b0;
    eng_last     = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic strobe(input logic [ENGW-1:0] d, input logic lst);
    eng_data  = d;
    eng_valid = 1'b1;
    eng_last  = lst;
    tick();
    eng_valid = 1'b0;
    eng_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [ENGW-1:0] d0;
  logic [ENGW-1:0] d1;

  initial begin
    rst = 1'b1;
    eng_data = '0;
    filter_en = 1'b0;
    packet_data_ready = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // reset / idle
    chk("rst_valid", packet_data_valid, 0);
    chk("rst_req", data_req, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_remain", packet_data_remain, 1);
    chk("rst_last", packet_data_last, 0);

    // single result, ready held high
    packet_data_ready = 1'b1;
    d0 = {128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB,
          128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA};
    strobe(d0, 1'b1);
    chk("single_valid", packet_data_valid, 1);
    chk("single_p0", packet_data, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    chk("single_rem0", packet_data_remain, 1);
    chk("single_last0", packet_data_last, 0);
    tick();
    chk("single_p1", packet_data, 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB);
    chk("single_rem1", packet_data_remain, 0);
    chk("single_last1", packet_data_last, 1);
    tick();
    chk("single_fill_end", fill_level, 0);
    chk("single_valid_end", packet_data_valid, 0);

    // filter on: only final digests stored
    packet_data_ready = 1'b0;
    filter_en = 1'b1;
    for (int i = 0; i < 4; i++) strobe({8{32'h1000_0000 + i}}, i[0]);
    chk("filter_fill", fill_level, 2);
    chk("filter_drop", drop_count, 0);
    chk("filter_req", data_req, 0);

    // filter off, 6 strobes into a 4-deep FIFO
    do_reset();
    filter_en = 1'b0;
    for (int i = 0; i < 6; i++) strobe({8{32'h2000_0000 + i}}, 1'b0);
    chk("ovf_fill", fill_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 2);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_flag", overflow, 0);
    chk("clr_drop", drop_count, 0);
    chk("clr_fill", fill_level, 4);

    // drop coincides with clear: drop wins
    overflow_clr = 1'b1;
    strobe({8{32'h3333_3333}}, 1'b0);
    overflow_clr = 1'b0;
    chk("dropclr_flag", overflow, 1);
    chk("dropclr_drop", drop_count, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;

    // at full, write coincides with final-sub-packet pop
    packet_data_ready = 1'b1;
    tick();
    chk("fullpop_last", packet_data_last, 1);
    d1 = {8{32'hD00D_F00D}};
    strobe(d1, 1'b0);
    packet_data_ready = 1'b0;
    chk("fullpop_fill", fill_level, 4);
    chk("fullpop_drop", drop_count, 0);
    chk("fullpop_head", packet_data, {4{32'h2000_0001}});

    // random ready drain with occasional strobes; model checks order/stability
    for (int i = 0; i < 60; i++) begin
      packet_data_ready = 1'($urandom_range(0, 1));
      eng_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      eng_valid = ($urandom_range(0, 3) == 0);
      eng_last  = 1'($urandom_range(0, 1));
      filter_en = 1'($urandom_range(0, 1));
      overflow_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle_inputs();
    filter_en = 1'b0;
    packet_data_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("drain_fill", fill_level, 0);

    // threshold of 3, then reset mid-entry
    packet_data_ready = 1'b0;
    strobe({8{32'h4000_0000}}, 1'b1);
    strobe({8{32'h4000_0001}}, 1'b1);
    chk("thr_req2", data_req, 0);
    chk("thr_fill2", fill_level, 2);
    strobe({8{32'h4000_0002}}, 1'b1);
    chk("thr_req3", data_req, 1);
    packet_data_ready = 1'b1;
    tick();
    chk("mid_last", packet_data_last, 1);
    do_reset();
    chk("rstmid_valid", packet_data_valid, 0);
    chk("rstmid_req", data_req, 0);
    chk("rstmid_fill", fill_level, 0);
    d1 = {128'hEEEE_0000_EEEE_1111_EEEE_2222_EEEE_3333,
          128'hEEEE_4444_EEEE_5555_EEEE_6666_EEEE_7777};
    strobe(d1, 1'b1);
    chk("post_rst_p0", packet_data, 128'hEEEE_4444_EEEE_5555_EEEE_6666_EEEE_7777);
    chk("post_rst_rem", packet_data_remain, 1);
    tick();
    tick();
    chk("post_rst_empty", packet_data_valid, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
